// File: rtl/mod107_pkg.sv
// rtl/mod107_pkg.sv - shared constants, FSM states and helpers for the mod-107 inverse unit
package mod107_pkg;

  localparam int MOD     = 107;
  localparam int RES_W   = 7;
  localparam int INV_EXP = MOD - 2;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SQR,
    MUL,
    DONE
  } inv_state_t;

  // Only a nonzero canonical residue has an inverse modulo a prime.
  function automatic logic is_residue(input logic [31:0] a, input logic [31:0] m);
    return (a != 32'd0) && (a < m);
  endfunction

endpackage

// File: rtl/mod107_mul_serial.sv
// rtl/mod107_mul_serial.sv - bit-serial interleaved shift-add modular multiplier
module mod107_mul_serial
  import mod107_pkg::*;
#(
  parameter int MODULUS = MOD,
  parameter int W       = RES_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] p
);

  localparam int           CW = $clog2(W + 1);
  localparam logic [W+1:0] M1 = (W+2)'(MODULUS);
  localparam logic [W+1:0] M2 = (W+2)'(2 * MODULUS);

  logic [W-1:0]  r_acc;
  logic [W-1:0]  r_x;
  logic [W-1:0]  r_y;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;

  // One Horner step: acc < M keeps 2*acc + y below 3M, so one of two
  // conditional subtractions is enough to land back in [0, M).
  function automatic logic [W-1:0] mod_step(input logic [W-1:0] acc,
                                            input logic         xb,
                                            input logic [W-1:0] yv);
    logic [W+1:0] t;
    t = {1'b0, acc, 1'b0} + (xb ? {2'b00, yv} : '0);
    if (t >= M2) begin
      t = t - M2;
    end else if (t >= M1) begin
      t = t - M1;
    end
    return t[W-1:0];
  endfunction

  // The start edge already consumes x's MSB, so a product takes exactly W edges
  // and done pulses in the cycle after the last one, ready for a chained start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_acc  <= mod_step('0, x[W-1], y);
        r_x    <= {x[W-2:0], 1'b0};
        r_y    <= y;
        r_cnt  <= CW'(W - 1);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_acc <= mod_step(r_acc, r_x[W-1], r_y);
        r_x   <= {r_x[W-2:0], 1'b0};
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign p    = r_acc;

endmodule

// File: rtl/mod107_inverse_seq.sv
// rtl/mod107_inverse_seq.sv - Fermat modular inverse a^(M-2) mod M by square-and-multiply
module mod107_inverse_seq
  import mod107_pkg::*;
#(
  parameter int MODULUS = MOD,
  parameter int W       = RES_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_inv,
  output logic         out_err
);

  localparam logic [W-1:0] EXP = W'(MODULUS - 2);
  localparam int           IW  = (W > 1) ? $clog2(W) : 1;

  inv_state_t   r_state;
  inv_state_t   w_state_nxt;

  logic [W-1:0] r_a;
  logic [IW-1:0] r_i;
  logic         r_in_ready;
  logic         r_out_valid;
  logic [W-1:0] r_inv;
  logic         r_err;

  logic         w_accept;
  logic         w_xfer;
  logic         w_mul_start;
  logic [W-1:0] w_mul_x;
  logic [W-1:0] w_mul_y;
  logic         w_mul_busy;
  logic         w_mul_done;
  logic         w_mul_fin;
  logic [W-1:0] w_mul_p;
  logic         w_init_i;
  logic         w_step_i;
  logic         w_fin_ok;
  logic         w_fin_err;

  assign w_accept  = in_valid & r_in_ready;
  assign w_xfer    = r_out_valid & out_ready;
  assign w_mul_fin = w_mul_done & ~w_mul_busy;

  // The running power r lives in the multiplier's product register; the FSM
  // feeds it straight back as the next operand so products chain with no gap.
  mod107_mul_serial #(
    .MODULUS(MODULUS),
    .W      (W)
  ) u_mul (
    .clk  (clk),
    .rst  (rst),
    .start(w_mul_start),
    .x    (w_mul_x),
    .y    (w_mul_y),
    .busy (w_mul_busy),
    .done (w_mul_done),
    .p    (w_mul_p)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, multiplier launch and operand select; the first square of r=1
  // is launched from CHECK with constant operands.
  always_comb begin
    w_state_nxt = r_state;
    w_mul_start = 1'b0;
    w_mul_x     = '0;
    w_mul_y     = '0;
    w_init_i    = 1'b0;
    w_step_i    = 1'b0;
    w_fin_ok    = 1'b0;
    w_fin_err   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (!is_residue(32'(r_a), 32'(MODULUS))) begin
          w_fin_err   = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_init_i    = 1'b1;
          w_mul_start = 1'b1;
          w_mul_x     = W'(1);
          w_mul_y     = W'(1);
          w_state_nxt = SQR;
        end
      end
      SQR: begin
        if (w_mul_fin) begin
          if (EXP[r_i]) begin
            w_mul_start = 1'b1;
            w_mul_x     = w_mul_p;
            w_mul_y     = r_a;
            w_state_nxt = MUL;
          end else if (r_i == '0) begin
            w_fin_ok    = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_step_i    = 1'b1;
            w_mul_start = 1'b1;
            w_mul_x     = w_mul_p;
            w_mul_y     = w_mul_p;
            w_state_nxt = SQR;
          end
        end
      end
      MUL: begin
        if (w_mul_fin) begin
          if (r_i == '0) begin
            w_fin_ok    = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_step_i    = 1'b1;
            w_mul_start = 1'b1;
            w_mul_x     = w_mul_p;
            w_mul_y     = w_mul_p;
            w_state_nxt = SQR;
          end
        end
      end
      DONE: begin
        if (w_xfer) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand latch, exponent bit index, result registers and handshake flags.
  // in_ready drops on the accept edge but rises one cycle after IDLE is
  // re-entered; out_valid likewise follows DONE by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_i         <= '0;
      r_inv       <= '0;
      r_err       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a <= in_a;
      end
      if (w_init_i) begin
        r_i <= IW'(W - 1);
      end else if (w_step_i) begin
        r_i <= r_i - 1'b1;
      end
      if (w_fin_ok) begin
        r_inv <= w_mul_p;
        r_err <= 1'b0;
      end else if (w_fin_err) begin
        r_inv <= '0;
        r_err <= 1'b1;
      end
      r_in_ready  <= w_accept ? 1'b0 : (r_state == IDLE);
      r_out_valid <= w_xfer ? 1'b0 : (r_state == DONE);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_inv   = r_inv;
  assign out_err   = r_err;

endmodule

// File: tb/tb_mod107_inverse_seq.sv
// tb/tb_mod107_inverse_seq.sv - directed self-checking bench for mod107_inverse_seq
module tb_mod107_inverse_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_a;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_inv;
  logic       out_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod107_inverse_seq dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_inv  (out_inv),
    .out_err  (out_err)
  );

  // Drives one operand and returns edges from accept to out_valid plus the result.
  task automatic run_op(input logic [6:0] a, output int lat, output logic [6:0] inv,
                        output logic err);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    in_valid = 1'b1;
    in_a     = a;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = 7'($urandom);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    inv = out_inv;
    err = out_err;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_inv !== 7'd0) begin errors++; $display("FAIL reset_out_inv: got %0d expected 0", out_inv); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err: got %b expected 0", out_err); end
  endtask

  task automatic test_directed();
    logic [6:0] va [5];
    logic [6:0] vi [5];
    int         lat;
    logic [6:0] inv;
    logic       err;
    va = '{7'd1, 7'd2, 7'd5, 7'd10, 7'd106};
    vi = '{7'd1, 7'd54, 7'd43, 7'd75, 7'd106};
    out_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      run_op(va[n], lat, inv, err);
      checks++; if (lat != 79) begin errors++; $display("FAIL dir_latency a=%0d: got %0d expected 79", va[n], lat); end
      checks++; if (inv !== vi[n]) begin errors++; $display("FAIL dir_inv a=%0d: got %0d expected %0d", va[n], inv, vi[n]); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL dir_err a=%0d: got %b expected 0", va[n], err); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dir_pulse a=%0d: out_valid got %b expected 0", va[n], out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL dir_ready_lag a=%0d: in_ready got %b expected 0", va[n], in_ready); end
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dir_ready_back a=%0d: in_ready got %b expected 1", va[n], in_ready); end
    end
  endtask

  task automatic test_errors();
    logic [6:0] va [3];
    int         lat;
    logic [6:0] inv;
    logic       err;
    va = '{7'd0, 7'd107, 7'd127};
    out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      run_op(va[n], lat, inv, err);
      checks++; if (lat != 2) begin errors++; $display("FAIL err_latency a=%0d: got %0d expected 2", va[n], lat); end
      checks++; if (inv !== 7'd0) begin errors++; $display("FAIL err_inv a=%0d: got %0d expected 0", va[n], inv); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_flag a=%0d: got %b expected 1", va[n], err); end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_exhaustive_stalls();
    int         lat;
    int         stall;
    logic [6:0] inv;
    logic       err;
    out_ready = 1'b0;
    for (int a = 1; a < 107; a++) begin
      run_op(7'(a), lat, inv, err);
      checks++;
      if (lat != 79 || err !== 1'b0 || ((int'(inv) * a) % 107) !== 1) begin
        errors++;
        $display("FAIL exh_inverse a=%0d: got inv=%0d err=%b lat=%0d expected inv*a%%107=1 err=0 lat=79", a, inv, err, lat);
      end
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_inv !== inv || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL exh_stall a=%0d: got valid=%b inv=%0d ready=%b expected valid=1 inv=%0d ready=0", a, out_valid, out_inv, in_ready, inv);
        end
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL exh_xfer a=%0d: out_valid got %b expected 0", a, out_valid); end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_abort();
    int         lat;
    logic [6:0] inv;
    logic       err;
    logic       seen;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = 7'd5;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    seen = 1'b0;
    repeat (39) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid: got %b expected 0", out_valid); end
    rst = 1'b0;
    repeat (100) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_result: got out_valid seen=%b expected 0", seen); end
    run_op(7'd3, lat, inv, err);
    checks++; if (lat != 79) begin errors++; $display("FAIL abort_fresh_latency: got %0d expected 79", lat); end
    checks++; if (inv !== 7'd36) begin errors++; $display("FAIL abort_fresh_inv: got %0d expected 36", inv); end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int         lat;
    int         k;
    logic       rdy;
    out_ready = 1'b1;
    @(negedge clk);
    k = 0;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    in_valid = 1'b1;
    in_a     = 7'd2;
    @(posedge clk);
    @(negedge clk);
    in_a = 7'd3;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    checks++; if (lat != 79) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 79", lat); end
    checks++; if (out_inv !== 7'd54) begin errors++; $display("FAIL b2b_first_inv: got %0d expected 54", out_inv); end
    @(posedge clk);
    k   = 0;
    rdy = 1'b0;
    while (!rdy && k < 10) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      k++;
    end
    checks++; if (k != 2) begin errors++; $display("FAIL b2b_accept_gap: got %0d edges expected 2", k); end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    checks++; if (lat != 79) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 79", lat); end
    checks++; if (out_inv !== 7'd36) begin errors++; $display("FAIL b2b_second_inv: got %0d expected 36", out_inv); end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_errors();
    test_exhaustive_stalls();
    test_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
